// File: rtl/skid_pkg.sv
// Shared types and state decode tables for the two-entry skid buffer.
package skid_pkg;

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_EMPTY = 2'd1,
    ST_ONE   = 2'd2,
    ST_FULL  = 2'd3
  } state_t;

  // One bit per state, indexed by the state encoding.
  // s_ready is high only while a slot is free and reset has been left.
  localparam logic [3:0] SREADY_BY_STATE = 4'b0110;
  // m_valid is high whenever at least one word is held.
  localparam logic [3:0] MVALID_BY_STATE = 4'b1100;

  // Number of words held in a given state.
  function automatic logic [1:0] occ_of(input state_t st);
    case (st)
      ST_ONE:  occ_of = 2'd1;
      ST_FULL: occ_of = 2'd2;
      default: occ_of = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/skid_buf.sv
// Two-entry valid/ready register slice. Forward and backward paths are both
// cut by flops: every handshake output is decoded from the state register only.
module skid_buf
  import skid_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic [1:0]    occ
);

  state_t        state_q, state_d;
  logic [DW-1:0] main_q, main_d;
  logic [DW-1:0] skid_q, skid_d;
  logic          in_xfer, out_xfer;

  // Handshake outputs come straight from the state register.
  assign s_ready  = SREADY_BY_STATE[state_q];
  assign m_valid  = MVALID_BY_STATE[state_q];
  assign occ      = occ_of(state_q);
  assign m_data   = main_q;

  assign in_xfer  = s_valid & s_ready;
  assign out_xfer = m_valid & m_ready;

  // Next state and register loads; main always holds the oldest word.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_RST: state_d = ST_EMPTY;
      ST_EMPTY: begin
        if (in_xfer) begin
          main_d  = s_data;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (in_xfer && out_xfer) begin
          main_d = s_data;
        end else if (in_xfer) begin
          // Downstream stalled: the in-flight word parks in the skid slot.
          skid_d  = s_data;
          state_d = ST_FULL;
        end else if (out_xfer) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // s_ready is low here, so upstream cannot transfer.
        if (out_xfer) begin
          main_d  = skid_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_RST;
    endcase
  end

  // State and data registers; reset discards any held words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RST;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: tb/tb_skid_buf.sv
// Randomized and directed bench for skid_buf against a queue-based model.
module tb_skid_buf;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic [1:0]    occ;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  skid_buf #(.DW(DW)) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .occ     (occ)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
  endtask

  // Behavioural model: a FIFO of held words, capacity 2, that only starts
  // accepting one edge after reset is released.
  logic [DW-1:0] mq[$];
  bit            started;
  int            acc_cnt;
  int            dut_dlv;

  function automatic bit mdl_sready();
    return started && (mq.size() < 2);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      started = 0;
    end else begin
      bit in_x, out_x;
      in_x  = s_valid && mdl_sready();
      out_x = (mq.size() > 0) && m_ready;
      if (out_x) void'(mq.pop_front());
      if (in_x) begin
        mq.push_back(s_data);
        acc_cnt++;
      end
      started = 1;
    end
  end

  // Count deliveries as seen on the DUT pins.
  always @(posedge clk) begin
    if (!rst && m_valid && m_ready) dut_dlv++;
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
      chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
      chk("rst_m_data", m_data, 32'd0);
      chk("rst_occ", {30'd0, occ}, 32'd0);
    end else begin
      chk("s_ready", {31'd0, s_ready}, {31'd0, mdl_sready()});
      chk("m_valid", {31'd0, m_valid}, {31'd0, mq.size() > 0});
      chk("occ", {30'd0, occ}, mq.size());
      if (mq.size() > 0) chk("m_data", m_data, mq[0]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0; s_data = '0;
    acc_cnt = 0; dut_dlv = 0;
    #1;
    chk("lit_rst_s_ready", {31'd0, s_ready}, 32'd0);
    chk("lit_rst_occ", {30'd0, occ}, 32'd0);
    step(); step();
    rst = 1'b0;
    chk("lit_rst_release_s_ready", {31'd0, s_ready}, 32'd0);
    step();
    chk("lit_first_edge_s_ready", {31'd0, s_ready}, 32'd1);

    // Streaming: one word per cycle, occupancy stays at 1.
    m_ready = 1'b1; s_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      s_data = i;
      step();
      chk("lit_stream_data", m_data, i);
      chk("lit_stream_occ", {30'd0, occ}, 32'd1);
    end
    s_valid = 1'b0;
    step();
    chk("lit_stream_empty_occ", {30'd0, occ}, 32'd0);

    // Backpressure fill.
    m_ready = 1'b0; s_valid = 1'b1; s_data = 32'hA1;
    step();
    s_data = 32'hA2;
    step();
    chk("lit_fill_occ", {30'd0, occ}, 32'd2);
    chk("lit_fill_s_ready", {31'd0, s_ready}, 32'd0);
    chk("lit_fill_data", m_data, 32'hA1);
    s_data = 32'hA3;
    step();
    chk("lit_fill_a3_occ", {30'd0, occ}, 32'd2);
    chk("lit_fill_a3_data", m_data, 32'hA1);
    s_valid = 1'b0;

    // Drain.
    m_ready = 1'b1;
    step();
    chk("lit_drain1_data", m_data, 32'hA2);
    chk("lit_drain1_occ", {30'd0, occ}, 32'd1);
    chk("lit_drain1_s_ready", {31'd0, s_ready}, 32'd1);
    step();
    chk("lit_drain2_occ", {30'd0, occ}, 32'd0);
    chk("lit_drain2_m_valid", {31'd0, m_valid}, 32'd0);

    // Random stalls: 1000 words.
    begin
      int base_acc, base_dlv, cyc;
      base_acc = acc_cnt; base_dlv = dut_dlv; cyc = 0;
      while ((dut_dlv - base_dlv) < 1000 && cyc < 20000) begin
        s_valid = ((acc_cnt - base_acc) < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
        s_data  = $urandom;
        m_ready = 1'($urandom_range(0, 1));
        step();
        cyc++;
      end
      chk("rand_delivered", dut_dlv - base_dlv, 32'd1000);
      s_valid = 1'b0; m_ready = 1'b0;
      step();
    end

    // Reset while FULL.
    s_valid = 1'b1; s_data = 32'hB1;
    step();
    s_data = 32'hB2;
    step();
    s_valid = 1'b0;
    chk("lit_b_full_occ", {30'd0, occ}, 32'd2);
    #3 rst = 1'b1;
    #1;
    chk("lit_midrst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("lit_midrst_m_data", m_data, 32'd0);
    chk("lit_midrst_occ", {30'd0, occ}, 32'd0);
    step();
    rst = 1'b0;
    step();
    m_ready = 1'b1; s_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_data = 32'hC0 + i;
      step();
      chk("lit_post_rst_data", m_data, 32'hC0 + i);
    end
    s_valid = 1'b0;
    step(); step();

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

// File: doc/skid_buf.md
# skid_buf

Two-entry valid/ready register slice (skid buffer) of parameterized width. It breaks both the forward data/valid path and the backward ready path with flops, so long streaming interfaces can be pipelined with full backpressure support. Throughput is one word per cycle and the forward latency is one cycle. The block sits between any producer/consumer pair in the datapath where a plain one-cycle `dff` stage cannot honour stalls.

## Interface
Parameters:
- `DW`, 32, data width in bits (≥1)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `s_valid`  in  1  upstream word valid
- `s_ready`  out  1  buffer can accept; registered output
- `s_data`  in  DW  upstream word
- `m_valid`  out  1  downstream word valid; registered output
- `m_ready`  in  1  downstream accepts
- `m_data`  out  DW  downstream word; registered output
- `occ`  out  2  number of words held (0..2)

## Operation
- Transfer rules: an upstream transfer occurs when `s_valid & s_ready`; a downstream transfer occurs when `m_valid & m_ready`.
- Storage: a main register drives `m_data`; a skid register holds the overflow word.
- FSM states, held in `skid_pkg::state_t`:
  - RST: entered on reset.
  - EMPTY: `occ=0`.
  - ONE: `occ=1`.
  - FULL: `occ=2`.
- RST:
  - Outputs: `s_ready=0`, `m_valid=0`.
  - Transition: always to EMPTY on the next edge.
- EMPTY:
  - Outputs: `s_ready=1`, `m_valid=0`.
  - `s_valid` → main<=`s_data`, go to ONE.
  - `!s_valid` → stay.
- ONE:
  - Outputs: `s_ready=1`, `m_valid=1`.
  - in&out → main<=`s_data`, stay.
  - in only → skid<=`s_data`, go to FULL.
  - out only → go to EMPTY.
  - neither → stay.
- FULL:
  - Outputs: `s_ready=0`, `m_valid=1`.
  - out → main<=skid, go to ONE.
  - no out → stay.
  - `s_valid` is ignored in FULL.
- Ordering: words leave in arrival order. No word is dropped or duplicated.
- `m_data` stays stable while `m_valid & !m_ready`.
- `s_valid` without `s_ready` is a legal upstream stall and causes no state change.
- `s_data` is sampled only on an upstream transfer.
- Data registers load only on the events listed above; they hold their value otherwise.

## Timing
- Reset values:
  - State: RST.
  - Outputs: `s_ready=0`, `m_valid=0`, `m_data=0`, `occ=0`.
  - Skid register: 0.
  - All values apply immediately on `rst` assertion, without a clock.
- After `rst` deassertion, `s_ready` rises at the first clock edge.
- Forward latency: a word accepted at edge N appears on `m_data` with `m_valid=1` after edge N. It can be consumed at edge N+1 at the earliest.
- Backward latency: deasserting `m_ready` while in ONE with a concurrent upstream transfer drops `s_ready` after that same edge. The in-flight word lands in the skid register, so no loss occurs.
- Sustained `s_valid=m_ready=1` gives one transfer per cycle in steady state, with the FSM staying in ONE.
- `s_ready`, `m_valid` and `occ` are pure functions of the state register; there is no combinational path from any input to any output.
- Reset mid-operation: held words are discarded. Outputs return to reset values asynchronously, and the sequence restarts at RST.

## Structure
- Package `skid_pkg`:
  - `state_t` enum: RST, EMPTY, ONE, FULL, 2-bit encoded.
  - Per-state constants for the registered `s_ready`/`m_valid` decode.
- Single flat module `skid_buf`:
  - One `always_ff` block with async reset for state and data.
  - One `always_comb` block for next-state and load enables.
- No sub-module is natural. The existing `dff` has no enable or reset and is not reused.

## Test plan
- Reset: assert `rst` mid-cycle → outputs `s_ready=0`, `m_valid=0`, `m_data=0`, `occ=0` immediately. Release `rst` → `s_ready=1` after one edge.
- Streaming: 16 words 0x00..0x0F with `m_ready=1` and `s_valid=1` continuously → output in order, one per cycle, first word one cycle after its input, `occ` constant at 1.
- Backpressure fill: `m_ready=0`, push 0xA1 then 0xA2 → `occ=2`, `s_ready=0`, `m_data=0xA1` stable. Extra `s_valid` with 0xA3 is not accepted.
- Drain: from FULL, `m_ready=1` for 2 cycles → outputs 0xA1 then 0xA2, and `occ` goes 2→1→0. `s_ready` returns to 1 after the first downstream transfer.
- Random stalls: 1000 words, random `s_valid`/`m_ready` each cycle → scoreboard shows exact in-order match. `m_data` stays stable during stalls, and `occ` equals accepted minus delivered.
- Reset in FULL: with 0xB1/0xB2 held, pulse `rst` → both words discarded, `m_valid=0`. Streaming afterwards outputs only new words.
